// File: rtl/nms_pkg.sv
// Shared types and constants for the NMS sequencer.
//   state_t    : sequencer states
//   REG_IDLE   : register file select meaning "no write this cycle"
//   NUM_REG    : entries in the score register file (ref + 8 neighbours)
//   nbrOffset  : (dx,dy) of register index 0..8 relative to the centre
package nms_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, EVAL, DONE} state_t;

  localparam logic [3:0] REG_IDLE = 4'hF;
  localparam int         NUM_REG  = 9;

  typedef struct packed {
    logic signed [1:0] dx;
    logic signed [1:0] dy;
  } offset_t;

  // Index 0 is the reference pixel, then the 3x3 window in raster order
  // with the centre skipped.
  function automatic offset_t nbrOffset(input logic [3:0] idx);
    offset_t o;
    o.dx = 2'sd0;
    o.dy = 2'sd0;
    case (idx)
      4'd1: begin o.dx = -2'sd1; o.dy = -2'sd1; end
      4'd2: begin o.dx =  2'sd0; o.dy = -2'sd1; end
      4'd3: begin o.dx =  2'sd1; o.dy = -2'sd1; end
      4'd4: begin o.dx = -2'sd1; o.dy =  2'sd0; end
      4'd5: begin o.dx =  2'sd1; o.dy =  2'sd0; end
      4'd6: begin o.dx = -2'sd1; o.dy =  2'sd1; end
      4'd7: begin o.dx =  2'sd0; o.dy =  2'sd1; end
      4'd8: begin o.dx =  2'sd1; o.dy =  2'sd1; end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/nms_addr_gen.sv
// Combinational neighbour address generator.
//   idx      : register index 0..8 selecting the (dx,dy) offset
//   centerX/Y: latched centre pixel
//   inBounds : neighbour lies inside the image
//   memAddr  : y*IMG_W + x of the neighbour, 0 when out of bounds
module nms_addr_gen import nms_pkg::*; #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int X_W    = 10,
  parameter int Y_W    = 9,
  parameter int ADDR_W = 19
) (
  input  logic [3:0]        idx,
  input  logic [X_W-1:0]    centerX,
  input  logic [Y_W-1:0]    centerY,
  output logic              inBounds,
  output logic [ADDR_W-1:0] memAddr
);

  offset_t            off;
  logic signed [31:0] px, py;

  always_comb begin
    off = nbrOffset(idx);
    // Signed 32-bit so that -1 at the left/top edge is seen as negative.
    px  = $signed({{(32-X_W){1'b0}}, centerX}) + $signed({{30{off.dx[1]}}, off.dx});
    py  = $signed({{(32-Y_W){1'b0}}, centerY}) + $signed({{30{off.dy[1]}}, off.dy});
    inBounds = (px >= 0) && (px < IMG_W) && (py >= 0) && (py < IMG_H);
    memAddr  = '0;
    // Only formed once the pixel is known to be inside the image, so the
    // truncated operands are exact.
    if (inBounds)
      memAddr = ADDR_W'(py) * ADDR_W'(IMG_W) + ADDR_W'(px);
  end

endmodule

// File: rtl/nms_ctrl.sv
// NMS sequencer: fetches the 9 FAST scores around (centerX,centerY) into the
// NMS register file, then samples the comparator and reports a keypoint.
//   clock/nReset       : clock, synchronous active-low reset
//   start,centerX/Y    : request, accepted only when idle
//   busy               : sequence in progress
//   memReq/memAddr     : score memory read, data back on memData next cycle
//   regAddr/scoreData  : register file write (REG_IDLE = no write)
//   readen/isMax       : register file output enable / comparator verdict
//   done/keypoint/kpX/kpY : one-cycle result pulse, result held until next
module nms_ctrl import nms_pkg::*; #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int X_W    = 10,
  parameter int Y_W    = 9,
  parameter int ADDR_W = 19
) (
  input  logic              clock,
  input  logic              nReset,
  input  logic              start,
  input  logic [X_W-1:0]    centerX,
  input  logic [Y_W-1:0]    centerY,
  output logic              busy,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  input  logic [7:0]        memData,
  output logic [3:0]        regAddr,
  output logic [7:0]        scoreData,
  output logic              readen,
  input  logic              isMax,
  output logic              done,
  output logic              keypoint,
  output logic [X_W-1:0]    kpX,
  output logic [Y_W-1:0]    kpY
);

  state_t            state, nextState;
  logic [3:0]        idx;
  logic [X_W-1:0]    cxLat;
  logic [Y_W-1:0]    cyLat;
  logic              inBounds;
  logic [ADDR_W-1:0] genAddr;

  // Write stage trails the fetch slot by one cycle to meet the memory latency.
  logic              wrVld, wrZero, refNonZero;
  logic [3:0]        wrIdx;

  nms_addr_gen #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)
  ) uAddrGen (
    .idx(idx), .centerX(cxLat), .centerY(cyLat),
    .inBounds(inBounds), .memAddr(genAddr)
  );

  always_ff @(posedge clock) begin
    if (!nReset) begin
      state      <= IDLE;
      idx        <= '0;
      cxLat      <= '0;
      cyLat      <= '0;
      wrVld      <= 1'b0;
      wrIdx      <= '0;
      wrZero     <= 1'b0;
      refNonZero <= 1'b0;
      keypoint   <= 1'b0;
      kpX        <= '0;
      kpY        <= '0;
    end else begin
      state  <= nextState;
      wrVld  <= (state == FETCH);
      wrIdx  <= idx;
      wrZero <= !inBounds;
      case (state)
        IDLE:  if (start) begin
                 cxLat <= centerX;
                 cyLat <= centerY;
                 idx   <= '0;
               end
        FETCH: idx <= idx + 4'd1;
        EVAL:  begin
                 keypoint <= isMax && refNonZero;
                 kpX      <= cxLat;
                 kpY      <= cyLat;
               end
        default: ;
      endcase
      // A zero reference score is never a keypoint, whatever the comparator says.
      if (wrVld && wrIdx == 4'd0)
        refNonZero <= (scoreData != 8'd0);
    end
  end

  always_comb begin
    nextState = state;
    busy      = (state != IDLE);
    memReq    = 1'b0;
    readen    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) nextState = FETCH;
      FETCH: begin
               memReq = inBounds;
               if (idx == 4'(NUM_REG - 1)) nextState = DRAIN;
             end
      DRAIN: nextState = EVAL;
      EVAL:  begin
               readen    = 1'b1;
               nextState = DONE;
             end
      DONE:  begin
               done      = 1'b1;
               nextState = IDLE;
             end
      default: nextState = IDLE;
    endcase
    memAddr   = memReq ? genAddr : '0;
    regAddr   = wrVld ? wrIdx : REG_IDLE;
    scoreData = (wrVld && !wrZero) ? memData : 8'd0;
  end

endmodule

// File: tb/tb_nms_ctrl.sv
module tb_nms_ctrl;
  localparam int X_W = 10, Y_W = 9, ADDR_W = 19;

  logic              clock = 1'b0;
  logic              nReset, start, isMax;
  logic [X_W-1:0]    centerX, kpX;
  logic [Y_W-1:0]    centerY, kpY;
  logic              busy, memReq, readen, done, keypoint;
  logic [ADDR_W-1:0] memAddr;
  logic [7:0]        memData, scoreData;
  logic [3:0]        regAddr;

  always #5 clock = ~clock;

  nms_ctrl #(.IMG_W(640), .IMG_H(480), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .nReset(nReset), .start(start), .centerX(centerX), .centerY(centerY),
    .busy(busy), .memReq(memReq), .memAddr(memAddr), .memData(memData),
    .regAddr(regAddr), .scoreData(scoreData), .readen(readen), .isMax(isMax),
    .done(done), .keypoint(keypoint), .kpX(kpX), .kpY(kpY)
  );

  int checks = 0, errors = 0;

  // Score memory: unset in-bounds pixels read 8'h5A; idle cycles return
  // 8'hEE so a write taken from a non-requested slot shows up.
  logic [7:0]        mem [int];
  logic              eReq   [9];
  logic [ADDR_W-1:0] eAddr  [9];
  logic [7:0]        eScore [9];
  logic              prevKp;
  logic [X_W-1:0]    prevX;
  logic [Y_W-1:0]    prevY;

  function automatic logic [7:0] rd(input logic [ADDR_W-1:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : 8'h5A;
  endfunction

  always @(posedge clock) memData <= memReq ? rd(memAddr) : 8'hEE;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic vec(input int i, input logic r, input int a, input logic [7:0] s);
    eReq[i]   = r;
    eAddr[i]  = r ? ADDR_W'(a) : '0;
    eScore[i] = r ? s : 8'd0;
    if (r) mem[a] = s;
  endtask

  task automatic loadCentre55();
    vec(0, 1, 3205, 8'd200); vec(1, 1, 2564, 8'd10); vec(2, 1, 2565, 8'd20);
    vec(3, 1, 2566, 8'd30);  vec(4, 1, 3204, 8'd40); vec(5, 1, 3206, 8'd50);
    vec(6, 1, 3844, 8'd60);  vec(7, 1, 3845, 8'd70); vec(8, 1, 3846, 8'd80);
  endtask

  task automatic runTxn(input string tag, input int cx, input int cy,
                        input logic wantMax, input logic expKp, input bit stray);
    logic [31:0] eR, eA, eRA, eSD;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clock);
      start   = (c == 0) || (stray && (c == 3 || c == 12));
      centerX = X_W'((c == 0) ? cx : cx + 2);
      centerY = Y_W'((c == 0) ? cy : cy + 2);
      isMax   = readen ? wantMax : !wantMax;
      eR = 0; eA = 0; eRA = 32'hF; eSD = 0;
      if (c >= 1 && c <= 9) begin
        eR = 32'(eReq[c-1]);
        eA = 32'(eAddr[c-1]);
      end
      if (c >= 2 && c <= 10) begin
        eRA = 32'(c - 2);
        eSD = 32'(eScore[c-2]);
      end
      check($sformatf("%s c%0d busy", tag, c),      32'(busy),      32'(c >= 1));
      check($sformatf("%s c%0d memReq", tag, c),    32'(memReq),    eR);
      check($sformatf("%s c%0d memAddr", tag, c),   32'(memAddr),   eA);
      check($sformatf("%s c%0d regAddr", tag, c),   32'(regAddr),   eRA);
      check($sformatf("%s c%0d scoreData", tag, c), 32'(scoreData), eSD);
      check($sformatf("%s c%0d readen", tag, c),    32'(readen),    32'(c == 11));
      check($sformatf("%s c%0d done", tag, c),      32'(done),      32'(c == 12));
      if (c == 6) begin
        check($sformatf("%s hold keypoint", tag), 32'(keypoint), 32'(prevKp));
        check($sformatf("%s hold kpX", tag),      32'(kpX),      32'(prevX));
        check($sformatf("%s hold kpY", tag),      32'(kpY),      32'(prevY));
      end
      if (c == 12) begin
        check($sformatf("%s keypoint", tag), 32'(keypoint), 32'(expKp));
        check($sformatf("%s kpX", tag),      32'(kpX),      32'(cx));
        check($sformatf("%s kpY", tag),      32'(kpY),      32'(cy));
      end
    end
    prevKp = expKp;
    prevX  = X_W'(cx);
    prevY  = Y_W'(cy);
  endtask

  task automatic runReset();
    for (int c = 0; c <= 14; c++) begin
      @(negedge clock);
      start   = (c == 0);
      centerX = 10'd5;
      centerY = 9'd5;
      isMax   = 1'b1;
      nReset  = (c != 6);
      if (c >= 1 && c <= 6)
        check($sformatf("rst c%0d busy", c), 32'(busy), 32'd1);
      if (c == 7) begin
        check("rst regAddr",   32'(regAddr),   32'hF);
        check("rst memReq",    32'(memReq),    32'd0);
        check("rst memAddr",   32'(memAddr),   32'd0);
        check("rst scoreData", 32'(scoreData), 32'd0);
        check("rst readen",    32'(readen),    32'd0);
        check("rst keypoint",  32'(keypoint),  32'd0);
        check("rst kpX",       32'(kpX),       32'd0);
      end
      if (c >= 7) begin
        check($sformatf("rst c%0d busy", c), 32'(busy), 32'd0);
        check($sformatf("rst c%0d done", c), 32'(done), 32'd0);
      end
    end
    prevKp = 1'b0;
    prevX  = '0;
    prevY  = '0;
  endtask

  initial begin
    nReset = 1'b0; start = 1'b0; centerX = '0; centerY = '0; isMax = 1'b0;
    repeat (2) @(negedge clock);
    check("reset busy",      32'(busy),      32'd0);
    check("reset memReq",    32'(memReq),    32'd0);
    check("reset memAddr",   32'(memAddr),   32'd0);
    check("reset regAddr",   32'(regAddr),   32'hF);
    check("reset scoreData", 32'(scoreData), 32'd0);
    check("reset readen",    32'(readen),    32'd0);
    check("reset done",      32'(done),      32'd0);
    check("reset keypoint",  32'(keypoint),  32'd0);
    check("reset kpX",       32'(kpX),       32'd0);
    check("reset kpY",       32'(kpY),       32'd0);
    nReset = 1'b1;
    prevKp = 1'b0; prevX = '0; prevY = '0;

    // Interior centre, comparator says max, then says not max.
    loadCentre55();
    runTxn("t1", 5, 5, 1'b1, 1'b1, 1'b0);
    runTxn("t2", 5, 5, 1'b0, 1'b0, 1'b0);

    // Top-left corner: five neighbours outside the image write zero.
    vec(0, 1, 0, 8'd90);  vec(1, 0, 0, 8'd0); vec(2, 0, 0, 8'd0);
    vec(3, 0, 0, 8'd0);   vec(4, 0, 0, 8'd0); vec(5, 1, 1, 8'd11);
    vec(6, 0, 0, 8'd0);   vec(7, 1, 640, 8'd12); vec(8, 1, 641, 8'd13);
    runTxn("t3", 0, 0, 1'b1, 1'b1, 1'b0);

    // Bottom-right corner with a zero reference score: no keypoint.
    vec(0, 1, 307199, 8'd0); vec(1, 1, 306558, 8'h21); vec(2, 1, 306559, 8'h22);
    vec(3, 0, 0, 8'd0);      vec(4, 1, 307198, 8'h23); vec(5, 0, 0, 8'd0);
    vec(6, 0, 0, 8'd0);      vec(7, 0, 0, 8'd0);       vec(8, 0, 0, 8'd0);
    runTxn("t4", 639, 479, 1'b1, 1'b0, 1'b0);

    // Stray starts in cycles 3 and 12, then a new start in cycle 13.
    loadCentre55();
    runTxn("t5", 5, 5, 1'b1, 1'b1, 1'b1);
    vec(0, 1, 638, 8'h61);  vec(1, 0, 0, 8'd0);     vec(2, 0, 0, 8'd0);
    vec(3, 0, 0, 8'd0);     vec(4, 1, 637, 8'h62);  vec(5, 1, 639, 8'h63);
    vec(6, 1, 1277, 8'h64); vec(7, 1, 1278, 8'h65); vec(8, 1, 1279, 8'h66);
    runTxn("t6", 638, 0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of FETCH, then a clean sequence.
    loadCentre55();
    runReset();
    runTxn("t7", 5, 5, 1'b1, 1'b1, 1'b0);

    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      start = 1'b0;
      check($sformatf("tail c%0d done", c), 32'(done), 32'd0);
      check($sformatf("tail c%0d busy", c), 32'(busy), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
